// File: rtl/phase_pkg.sv
// Shared types and constants for the two-road phase scheduler.
package phase_pkg;

  // Phase encoding is visible on the phase output port.
  typedef enum logic [1:0] {
    GREEN_A = 2'd0,
    CLEAR_A = 2'd1,
    GREEN_B = 2'd2,
    CLEAR_B = 2'd3
  } phase_t;

  // Green-duration clamp windows, in ticks.
  localparam logic [6:0] A_MIN_NORM = 7'd40;
  localparam logic [6:0] A_MAX_NORM = 7'd70;
  localparam logic [6:0] B_MIN_NORM = 7'd50;
  localparam logic [6:0] B_MAX_NORM = 7'd80;
  localparam logic [6:0] A_MIN_RUSH = 7'd30;
  localparam logic [6:0] A_MAX_RUSH = 7'd60;
  localparam logic [6:0] B_MIN_RUSH = 7'd40;
  localparam logic [6:0] B_MAX_RUSH = 7'd70;

  // Queue-length thresholds and the step applied to a duration.
  localparam logic [4:0] CNT_LOW  = 5'd10;
  localparam logic [4:0] CNT_HIGH = 5'd20;
  localparam logic [6:0] ADJ_STEP = 7'd5;

endpackage

// File: rtl/phase_duration_calc.sv
// Combinational adjust-and-clamp of one road's green duration.
module phase_duration_calc
  import phase_pkg::*;
(
  input  logic [4:0] count,
  input  logic       rush,
  input  logic       road_b,
  input  logic [6:0] cur_dur,
  output logic [6:0] next_dur
);

  logic [6:0] adj;
  logic [6:0] lo;
  logic [6:0] hi;

  // Stored durations never drop below 30, so the subtract cannot wrap;
  // the add peaks at 85, well inside 7 bits.
  always_comb begin
    adj = cur_dur;
    if (count <= CNT_LOW)
      adj = cur_dur + ADJ_STEP;
    else if (count >= CNT_HIGH)
      adj = cur_dur - ADJ_STEP;

    case ({road_b, rush})
      2'b00:   begin lo = A_MIN_NORM; hi = A_MAX_NORM; end
      2'b01:   begin lo = A_MIN_RUSH; hi = A_MAX_RUSH; end
      2'b10:   begin lo = B_MIN_NORM; hi = B_MAX_NORM; end
      default: begin lo = B_MIN_RUSH; hi = B_MAX_RUSH; end
    endcase

    next_dur = adj;
    if (adj < lo)
      next_dur = lo;
    else if (adj > hi)
      next_dur = hi;
  end

endmodule

// File: rtl/phase_scheduler.sv
// Two-road traffic phase scheduler with queue-adaptive green durations.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int unsigned DUR_A_INIT  = 40,
  parameter int unsigned DUR_B_INIT  = 50,
  parameter int unsigned CLEAR_TICKS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       hold,
  input  logic       rushHour,
  input  logic [4:0] numOfCarsA,
  input  logic [4:0] numOfCarsB,
  output logic       greenForA,
  output logic       greenForB,
  output logic [6:0] remainingTime,
  output logic [1:0] phase
);

  phase_t     state, state_n;
  logic [6:0] rem_n;
  logic [6:0] dur_a, dur_a_n;
  logic [6:0] dur_b, dur_b_n;
  logic       calc_road_b;
  logic [4:0] calc_count;
  logic [6:0] calc_cur;
  logic [6:0] calc_next;

  // Only one road is adjusted per GREEN->CLEAR tick, so one calculator is
  // shared: leaving GREEN_A updates B, leaving GREEN_B updates A.
  assign calc_road_b = (state == GREEN_A);
  assign calc_count  = calc_road_b ? numOfCarsB : numOfCarsA;
  assign calc_cur    = calc_road_b ? dur_b : dur_a;

  phase_duration_calc u_calc (
    .count    (calc_count),
    .rush     (rushHour),
    .road_b   (calc_road_b),
    .cur_dur  (calc_cur),
    .next_dur (calc_next)
  );

  // Next-state and countdown logic; everything holds unless an unheld tick.
  always_comb begin
    state_n = state;
    rem_n   = remainingTime;
    dur_a_n = dur_a;
    dur_b_n = dur_b;
    if (tick && !hold) begin
      if (remainingTime != 7'd0) begin
        rem_n = remainingTime - 7'd1;
      end else begin
        case (state)
          GREEN_A: begin
            state_n = CLEAR_A;
            rem_n   = 7'(CLEAR_TICKS);
            dur_b_n = calc_next;
          end
          CLEAR_A: begin
            state_n = GREEN_B;
            rem_n   = dur_b;
          end
          GREEN_B: begin
            state_n = CLEAR_B;
            rem_n   = 7'(CLEAR_TICKS);
            dur_a_n = calc_next;
          end
          default: begin
            state_n = GREEN_A;
            rem_n   = dur_a;
          end
        endcase
      end
    end
  end

  // State, timers and registered green outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= GREEN_A;
      remainingTime <= 7'(DUR_A_INIT);
      dur_a         <= 7'(DUR_A_INIT);
      dur_b         <= 7'(DUR_B_INIT);
      greenForA     <= 1'b1;
      greenForB     <= 1'b0;
    end else begin
      state         <= state_n;
      remainingTime <= rem_n;
      dur_a         <= dur_a_n;
      dur_b         <= dur_b_n;
      greenForA     <= (state_n == GREEN_A);
      greenForB     <= (state_n == GREEN_B);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic       rushHour = 1'b0;
  logic [4:0] numOfCarsA = 5'd15;
  logic [4:0] numOfCarsB = 5'd15;
  logic       greenForA;
  logic       greenForB;
  logic [6:0] remainingTime;
  logic [1:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state (plain integers; phase 0..3 = GA, CA, GB, CB).
  int m_ph, m_rem, m_da, m_db;

  phase_scheduler #(
    .DUR_A_INIT (40),
    .DUR_B_INIT (50),
    .CLEAR_TICKS(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .hold         (hold),
    .rushHour     (rushHour),
    .numOfCarsA   (numOfCarsA),
    .numOfCarsB   (numOfCarsB),
    .greenForA    (greenForA),
    .greenForB    (greenForB),
    .remainingTime(remainingTime),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  function automatic int adj(int cnt, bit rush, bit road_b, int cur);
    int d, lo, hi;
    d = cur;
    if (cnt <= 10) d = cur + 5;
    else if (cnt >= 20) d = cur - 5;
    if (road_b) lo = rush ? 40 : 50;
    else        lo = rush ? 30 : 40;
    hi = lo + 30;
    if (d < lo) d = lo;
    if (d > hi) d = hi;
    return d;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model with the same inputs, compare outputs.
  task automatic step(input bit r, input bit t, input bit h, input bit ru,
                      input int ca, input int cb);
    rst = r; tick = t; hold = h; rushHour = ru;
    numOfCarsA = 5'(ca); numOfCarsB = 5'(cb);
    @(posedge clk);
    #1;
    if (r) begin
      m_ph = 0; m_rem = 40; m_da = 40; m_db = 50;
    end else if (t && !h) begin
      if (m_rem != 0) m_rem--;
      else begin
        case (m_ph)
          0: begin m_db = adj(cb, ru, 1'b1, m_db); m_ph = 1; m_rem = 0; end
          1: begin m_ph = 2; m_rem = m_db; end
          2: begin m_da = adj(ca, ru, 1'b0, m_da); m_ph = 3; m_rem = 0; end
          default: begin m_ph = 0; m_rem = m_da; end
        endcase
      end
    end
    n_tests++;
    if (remainingTime != 7'(m_rem) || phase != 2'(m_ph) ||
        greenForA != (m_ph == 0) || greenForB != (m_ph == 2)) begin
      n_fail++;
      $display("FAIL model_step: got rem=%0d ph=%0d gA=%0b gB=%0b expected rem=%0d ph=%0d gA=%0b gB=%0b",
               remainingTime, phase, greenForA, greenForB,
               m_rem, m_ph, (m_ph == 0), (m_ph == 2));
    end
    rst = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n, input bit ru, input int ca, input int cb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, ru, ca, cb);
  endtask

  typedef struct {
    int cnt_b;
    bit rush;
    int exp_rem;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{5,  1'b0, 55};
    tbl[1] = '{10, 1'b0, 55};
    tbl[2] = '{11, 1'b0, 50};
    tbl[3] = '{19, 1'b0, 50};
    tbl[4] = '{20, 1'b0, 50};
    tbl[5] = '{31, 1'b0, 50};
    tbl[6] = '{20, 1'b1, 45};
    tbl[7] = '{0,  1'b1, 55};
    tbl[8] = '{15, 1'b1, 50};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
    check("reset_rem", remainingTime, 40);
    check("reset_phase", phase, 0);
    check("reset_gA", greenForA, 1);
    check("reset_gB", greenForB, 0);

    // 40 ticks run A down to zero, the 41st enters all-red.
    ticks(40, 1'b0, 15, 15);
    check("ga_end_rem", remainingTime, 0);
    check("ga_end_gA", greenForA, 1);
    ticks(1, 1'b0, 15, 15);
    check("clear_a_phase", phase, 1);
    check("clear_a_greens", {greenForA, greenForB}, 0);

    // Table: count/rush for B at the GREEN_A->CLEAR_A tick.
    foreach (tbl[k]) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
      ticks(40, 1'b0, 15, 15);
      ticks(1, tbl[k].rush, 15, tbl[k].cnt_b);
      ticks(1, 1'b0, 15, 15);
      check($sformatf("tbl%0d_rem", k), remainingTime, tbl[k].exp_rem);
      check($sformatf("tbl%0d_gB", k), greenForB, 1);
    end

    // A congested, rush hour vs. normal at the B->clear tick.
    for (int r = 1; r >= 0; r--) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
      ticks(42, 1'b0, 15, 15);
      ticks(50, 1'b0, 15, 15);
      check("gb_end_rem", remainingTime, 0);
      ticks(1, 1'(r), 25, 15);
      check("clear_b_phase", phase, 3);
      ticks(1, 1'b0, 15, 15);
      check(r ? "rush_a_load" : "norm_a_clamp", remainingTime, r ? 35 : 40);
      check("ga_phase", phase, 0);
    end

    // Hold freezes mid GREEN_B; rush toggles under hold are ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
    ticks(47, 1'b0, 15, 15);
    check("pre_hold_rem", remainingTime, 45);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'(i % 2), 0, 0);
    check("hold_rem", remainingTime, 45);
    check("hold_phase", phase, 2);
    ticks(1, 1'b0, 15, 15);
    check("release_rem", remainingTime, 44);

    // Reset together with a tick in CLEAR_B.
    step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
    ticks(41, 1'b0, 15, 0);
    ticks(1, 1'b0, 15, 15);
    check("gb_load_55", remainingTime, 55);
    ticks(56, 1'b0, 15, 15);
    check("in_clear_b", phase, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 15, 15);
    check("rst_tick_phase", phase, 0);
    check("rst_tick_rem", remainingTime, 40);
    ticks(42, 1'b0, 15, 15);
    check("durb_restored", remainingTime, 50);

    // Empty B queue every cycle: durB climbs in steps of 5 and saturates.
    step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
    for (int k = 1; k <= 8; k++) begin
      int exp_b;
      exp_b = (50 + 5 * k > 80) ? 80 : 50 + 5 * k;
      ticks(41, 1'b0, 15, 0);
      ticks(1, 1'b0, 15, 0);
      check($sformatf("sat_b%0d", k), remainingTime, exp_b);
      ticks(exp_b + 2, 1'b0, 15, 0);
      check($sformatf("sat_ga%0d", k), phase, 0);
    end

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
